neuron_acc: RTL and testbench



---
 rtl/neuron_pkg.sv | 22 ++
 rtl/neuron_acc_fxp_mul.sv | 29 ++
 rtl/neuron_acc.sv | 134 +++++++++++++
 tb/tb_neuron_acc.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | neuron_pkg : shared FSM state type and Q8.23 constants for the     |
// |              neuron accumulator and its fixed-point multiplier.    |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
package neuron_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_BIAS = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int unsigned FRAC_Q    = 23;
  localparam logic [31:0] ONE_Q     = 32'h0080_0000;
  localparam logic [31:0] SAT_MAX_Q = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_MIN_Q = 32'h8000_0000;

endpackage
`default_nettype wire

// File: rtl/neuron_acc_fxp_mul.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fxp_mul : combinational signed DWIDTH x DWIDTH multiply, full      |
// |           2*DWIDTH product arithmetically shifted right by FRAC.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module fxp_mul #(
  parameter int DWIDTH = 32,
  parameter int FRAC   = 23
) (
  input  logic signed [DWIDTH-1:0]   a_i,
  input  logic signed [DWIDTH-1:0]   b_i,
  output logic signed [2*DWIDTH-1:0] p_o
);

  logic signed [2*DWIDTH-1:0] a_ext_w;
  logic signed [2*DWIDTH-1:0] b_ext_w;
  logic signed [2*DWIDTH-1:0] prod_w;

  always_comb begin
    a_ext_w = $signed({{DWIDTH{a_i[DWIDTH-1]}}, a_i});
    b_ext_w = $signed({{DWIDTH{b_i[DWIDTH-1]}}, b_i});
    prod_w  = a_ext_w * b_ext_w;
    // Arithmetic shift floors toward minus infinity.
    p_o     = prod_w >>> FRAC;
  end

endmodule
`default_nettype wire

// File: rtl/neuron_acc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | neuron_acc : multiply-accumulate of IWIDTH Q8.23 pairs plus bias,  |
// |              result returned through a valid/ready handshake.      |
// | Build macro: NEURON_ACC_SAT_EN (saturating result, else wrapping)  |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
module neuron_acc
  import neuron_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int FRAC   = FRAC_Q,
  parameter int IWIDTH = 64,
  parameter int GUARD  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DWIDTH-1:0] bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] k_in,
  input  logic [DWIDTH-1:0] w_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] sum_out,
  output logic              busy
);

  localparam int ACCW = DWIDTH + GUARD;
  localparam int CNTW = (IWIDTH > 1) ? $clog2(IWIDTH) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(IWIDTH - 1);

  state_t                   state_q, state_d;
  logic signed [ACCW-1:0]   acc_q, acc_d;
  logic [CNTW-1:0]          cnt_q, cnt_d;
  logic signed [DWIDTH-1:0] bias_q, bias_d;
  logic [DWIDTH-1:0]        sum_q, sum_d;

  logic signed [2*DWIDTH-1:0] prod_w;
  logic signed [ACCW-1:0]     biased_w;
  logic [DWIDTH-1:0]          clip_w;

  fxp_mul #(
    .DWIDTH (DWIDTH),
    .FRAC   (FRAC)
  ) u_mul (
    .a_i (k_in),
    .b_i (w_in),
    .p_o (prod_w)
  );

  assign biased_w = acc_q + ACCW'(bias_q);

`ifdef NEURON_ACC_SAT_EN
  localparam logic signed [ACCW-1:0] SAT_HI = (ACCW'(1) <<< (DWIDTH - 1)) - ACCW'(1);
  localparam logic signed [ACCW-1:0] SAT_LO = ~SAT_HI;

  always_comb begin
    clip_w = biased_w[DWIDTH-1:0];
    if (biased_w > SAT_HI) begin
      clip_w = SAT_HI[DWIDTH-1:0];
    end else if (biased_w < SAT_LO) begin
      clip_w = SAT_LO[DWIDTH-1:0];
    end
  end
`else
  assign clip_w = biased_w[DWIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      bias_q  <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bias_q  <= bias_d;
      sum_q   <= sum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bias_d  = bias_q;
    sum_d   = sum_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          bias_d  = bias;
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        if (in_valid) begin
          // Product truncated to accumulator width; in-range inputs never lose sign here.
          acc_d = acc_q + ACCW'(prod_w);
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_BIAS;
          end
        end
      end
      ST_BIAS: begin
        acc_d   = biased_w;
        sum_d   = clip_w;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_ACC);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
    sum_out   = sum_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_neuron_acc.sv
`default_nettype none
// Bench for neuron_acc: directed Q8.23 patterns plus randomized evaluations
// checked every output-valid cycle against a plain-arithmetic model.
module tb_neuron_acc;

  localparam int NP = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] bias;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] k_in;
  logic [31:0] w_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum_out;
  logic        busy;

  int          total = 0;
  int          bad = 0;
  int          k_arr[NP];
  int          w_arr[NP];
  logic [31:0] exp_q[$];
  int          episodes = 0;
  int          evals = 0;
  bit          prev_ov = 1'b0;

  neuron_acc dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .k_in      (k_in),
    .w_in      (w_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Reference: exact integer sum of floored Q8.23 products plus bias, then clip.
  function automatic logic [31:0] model(input int b);
    longint s;
    s = 0;
    for (int i = 0; i < NP; i++) begin
      s += (longint'(k_arr[i]) * longint'(w_arr[i])) >>> 23;
    end
    s += longint'(b);
`ifdef NEURON_ACC_SAT_EN
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    else if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
    return s[31:0];
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      check("ready_valid_excl", {31'b0, in_ready & out_valid}, 32'd0);
      if (out_valid) begin
        if (exp_q.size() == 0) check("unexpected_out_valid", 32'd1, 32'd0);
        else check("sum_vs_model", sum_out, exp_q[0]);
        if (!prev_ov) episodes++;
      end
    end
    prev_ov = out_valid;
  end

  task automatic fill_const(input int k, input int w);
    for (int i = 0; i < NP; i++) begin
      k_arr[i] = k;
      w_arr[i] = w;
    end
  endtask

  task automatic fill_rand();
    int x;
    for (int i = 0; i < NP; i++) begin
      x = $urandom;
      k_arr[i] = x >>> 4;
      x = $urandom;
      w_arr[i] = x >>> 4;
    end
  endtask

  task automatic do_eval(input int b, input int gap_pct, input int hold, input bit noise,
                         input bit use_lit, input logic [31:0] lit, input string tag);
    int i;
    int cyc;
    exp_q.push_back(model(b));
    evals++;
    start = 1'b1;
    bias  = b;
    @(negedge clk);
    start = 1'b0;
    bias  = $urandom;
    check({tag, "_ready_after_start"}, {31'b0, in_ready}, 32'd1);
    i   = 0;
    cyc = 0;
    while (i < NP && cyc < 2000) begin
      if (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        k_in = $urandom;
        w_in = $urandom;
      end else begin
        in_valid = 1'b1;
        k_in = k_arr[i];
        w_in = w_arr[i];
        i++;
      end
      start = noise ? 1'($urandom_range(1)) : 1'b0;
      cyc++;
      @(negedge clk);
    end
    if (i < NP) check({tag, "_feed_timeout"}, 32'd1, 32'd0);
    // Junk pairs and start outside ACC must be ignored.
    start    = 1'b0;
    in_valid = 1'b1;
    k_in     = $urandom;
    w_in     = $urandom;
    check({tag, "_bias_cycle_valid"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_bias_cycle_ready"}, {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    check({tag, "_valid_at_last_plus_2"}, {31'b0, out_valid}, 32'd1);
    if (use_lit) check({tag, "_sum_literal"}, sum_out, lit);
    for (int j = 0; j < hold; j++) begin
      start = 1'b1;
      @(negedge clk);
    end
    check({tag, "_valid_after_hold"}, {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    check({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_idle_valid"}, {31'b0, out_valid}, 32'd0);
    void'(exp_q.pop_front());
    @(negedge clk);
    check({tag, "_no_extra_eval"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic reset_mid_eval();
    fill_rand();
    start = 1'b1;
    bias  = 32'h0123_4567;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1;
      k_in = k_arr[i];
      w_in = w_arr[i];
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_sum_out", sum_out, 32'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bias = '0;
    in_valid = 1'b0;
    k_in = '0;
    w_in = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", {31'b0, in_ready}, 32'd0);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_sum_out", sum_out, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1.0 * 0.5 summed 64 times = 32.0
    fill_const(32'h0080_0000, 32'h0040_0000);
    do_eval(0, 0, 0, 1'b0, 1'b1, 32'h1000_0000, "half");
    // zero inputs leave only the bias
    fill_const(0, 32'h1234_5678);
    do_eval(32'h0180_0000, 0, 0, 1'b0, 1'b1, 32'h0180_0000, "bias_only");
    // 1.0 * -0.25 summed 64 times = -16.0
    fill_const(32'h0080_0000, 32'hFFE0_0000);
    do_eval(0, 0, 0, 1'b0, 1'b1, 32'hF800_0000, "neg_quarter");
    // 64 * 127.0 = 8128.0 = 0xFE0000000 in Q8.23, beyond 32 bits
    fill_const(32'h0080_0000, 32'h3F80_0000);
`ifdef NEURON_ACC_SAT_EN
    do_eval(0, 0, 0, 1'b0, 1'b1, 32'h7FFF_FFFF, "overflow");
`else
    do_eval(0, 0, 0, 1'b0, 1'b1, 32'hE000_0000, "overflow");
`endif

    fill_rand();
    do_eval(int'($urandom) >>> 2, 30, 5, 1'b1, 1'b0, 32'd0, "stall_hold5");
    for (int n = 0; n < 6; n++) begin
      fill_rand();
      do_eval(int'($urandom) >>> 2, 40, int'($urandom_range(6)), 1'b1, 1'b0, 32'd0, "random");
    end

    reset_mid_eval();
    fill_const(32'h0080_0000, 32'h0040_0000);
    do_eval(0, 20, 2, 1'b1, 1'b1, 32'h1000_0000, "after_reset");

    check("out_valid_episodes", episodes, evals);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
